// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the framed program loader.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [7:0]  DEFAULT_MAGIC   = 8'hA5;
  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam int unsigned LEN_W           = 16;

  // States in which the inter-byte timeout is armed.
  function automatic logic in_frame(state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/boot_loader_timer.sv
// Idle-cycle counter: expires on the TIMEOUT-th consecutive enabled, uncleared cycle.
module boot_loader_timer #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned   CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Framed byte-stream loader: writes a checksummed image into instruction memory
// and holds the cpu in reset until the image is verified.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter logic [7:0]  MAGIC   = DEFAULT_MAGIC,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic              reload_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1 << ADDR_W);

  state_e            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_q, word_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              acc;
  logic              active;
  logic              tmo_expired;
  logic [LEN_W-1:0]  len_full;
  logic [ADDR_W:0]   word_inc;

  assign acc      = rx_valid_i && rx_ready_q;
  assign active   = in_frame(state_q);
  assign len_full = {len_hi_q, rx_data_i};
  assign word_inc = word_q + 1'b1;

  boot_loader_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (acc || reload_i),
    .enable_i  (active),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    len_hi_d     = len_hi_q;
    len_d        = len_q;
    word_d       = word_q;
    bcnt_d       = bcnt_q;
    asm_d        = asm_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    if (reload_i) begin
      state_d = ST_IDLE;
    end else if (tmo_expired) begin
      state_d = ST_ERR;
    end else if (acc) begin
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (rx_data_i == MAGIC) begin
            state_d = ST_LEN_HI;
            csum_d  = '0;
            word_d  = '0;
            bcnt_d  = '0;
          end
        end
        ST_LEN_HI: begin
          len_hi_d = rx_data_i;
          state_d  = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d = len_full[ADDR_W:0];
          if (len_full == '0) begin
            state_d = ST_CSUM;
          end else if (len_full > MAX_WORDS) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          asm_d  = {asm_q[15:0], rx_data_i};
          csum_d = csum_q ^ rx_data_i;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_q[ADDR_W-1:0];
            imem_wdata_d = {asm_q, rx_data_i};
            word_d       = word_inc;
            if (word_inc == len_q) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          state_d = (rx_data_i == csum_q) ? ST_DONE : ST_ERR;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Status outputs are registered copies of the next state so they line up with state_q.
    rx_ready_d = (state_d != ST_DONE);
    cpu_rst_d  = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      word_q       <= '0;
      bcnt_q       <= '0;
      asm_q        <= '0;
      csum_q       <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_hi_q     <= len_hi_d;
      len_q        <= len_d;
      word_q       <= word_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule
